test_pattern_sequencer: RTL and testbench

Frame-synchronous scheduler that selects which test pattern drives the 3-bit RGB output of the video chain. It sits after the hvsync generator and consumes hpos, vpos, display_on and vsync. Built-in patterns: SMPTE bars, checkerboard, ramp and cycling solid colour. It advances automatically every FRAMES_PER_PATTERN frames or on a user button, and switches only at frame boundaries so there is no tearing.

---
 rtl/test_pattern_sequencer_if.sv | 42 ++++
 rtl/test_pattern_sequencer.sv | 248 ++++++++++++++++++++++++
 tb/tb_test_pattern_sequencer.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/test_pattern_sequencer_if.sv
// ---------------------------------------------------------------------------
// test_pattern_sequencer_if
//
// Purpose: bundles the video-timing inputs, user controls and pixel/status
// outputs of the test pattern sequencer into one interface.
//
// Signals:
//   hpos[8:0]       horizontal position from the hvsync generator
//   vpos[8:0]       vertical position from the hvsync generator
//   display_on      high in the visible region
//   vsync           vertical sync, active-high
//   next_btn        asynchronous manual-advance button, active-high
//   hold            freezes auto-advance while high
//   pattern_id[1:0] current pattern (0 BARS, 1 CHECKER, 2 RAMP, 3 SOLID)
//   frame_tick      one-cycle pulse per frame
//   rgb[2:0]        {r,g,b} pixel output
//
// Modports:
//   master - the side that produces timing/controls and consumes pixels
//   slave  - the sequencer itself
// ---------------------------------------------------------------------------
interface test_pattern_sequencer_if;
  logic [8:0] hpos;
  logic [8:0] vpos;
  logic       display_on;
  logic       vsync;
  logic       next_btn;
  logic       hold;
  logic [1:0] pattern_id;
  logic       frame_tick;
  logic [2:0] rgb;

  modport master (
    output hpos, vpos, display_on, vsync, next_btn, hold,
    input  pattern_id, frame_tick, rgb
  );

  modport slave (
    input  hpos, vpos, display_on, vsync, next_btn, hold,
    output pattern_id, frame_tick, rgb
  );
endinterface

// File: rtl/test_pattern_sequencer.sv
// ---------------------------------------------------------------------------
// test_pattern_sequencer
//
// Purpose: frame-synchronous scheduler choosing which built-in test pattern
// (SMPTE bars, checkerboard, ramp, cycling solid colour) drives the 3-bit RGB
// output. The pattern advances every FRAMES_PER_PATTERN frames (unless hold
// is high) or on a button press, and only ever changes on a vsync rising
// edge, so a visible frame never mixes two patterns.
//
// Ports:
//   clk    in   pixel clock
//   reset  in   asynchronous, active-high; clears all state immediately
//   bus    slave modport of test_pattern_sequencer_if
//            in : hpos, vpos, display_on, vsync, next_btn, hold
//            out: pattern_id, frame_tick, rgb
//
// Parameters:
//   H_DISPLAY           visible pixels per line (sizes the bar sub-counter)
//   BAR_WIDTH           pixels per SMPTE bar; columns >= 7*BAR_WIDTH are black
//   FRAMES_PER_PATTERN  auto-advance period in frames, 1..255
//
// Build option:
//   PATTERN_OSD_EN  when defined, draws pattern_id+1 white 7-pixel blocks in
//                   the top-left corner (vpos<8) on top of the pattern.
// ---------------------------------------------------------------------------
module test_pattern_sequencer #(
  parameter int H_DISPLAY          = 256,
  parameter int BAR_WIDTH          = 36,
  parameter int FRAMES_PER_PATTERN = 60
) (
  input logic                     clk,
  input logic                     reset,
  test_pattern_sequencer_if.slave bus
);

  // Sub-counter wide enough for a bar as wide as the whole line.
  localparam int SUB_W = $clog2(H_DISPLAY + 1);
  localparam logic [SUB_W-1:0] BAR_LAST   = SUB_W'(BAR_WIDTH - 1);
  localparam logic [7:0]       FRAME_LAST = 8'(FRAMES_PER_PATTERN - 1);

  typedef enum logic [1:0] {
    PAT_BARS    = 2'd0,
    PAT_CHECKER = 2'd1,
    PAT_RAMP    = 2'd2,
    PAT_SOLID   = 2'd3
  } pattern_e;

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  pattern_e         pattern_q,   pattern_d;
  logic [7:0]       frame_cnt_q, frame_cnt_d;
  logic             pending_q,   pending_d;
  logic [2:0]       solid_col_q, solid_col_d;
  logic [2:0]       bar_idx_q,   bar_idx_d;
  logic [SUB_W-1:0] bar_sub_q,   bar_sub_d;
  logic [2:0]       rgb_q,       rgb_d;
  logic             vsync_q;
  logic             frame_tick_q;
  logic [1:0]       btn_sync_q;
  logic             btn_prev_q;

  logic             frame_start;
  logic             btn_edge;
  logic             advance;

  assign frame_start = bus.vsync & ~vsync_q;
  // Rising edge of the synchronised button.
  assign btn_edge    = btn_sync_q[1] & ~btn_prev_q;

  // -------------------------------------------------------------------------
  // Frame-start detection and button synchroniser
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vsync_q      <= 1'b0;
      frame_tick_q <= 1'b0;
      btn_sync_q   <= 2'b00;
      btn_prev_q   <= 1'b0;
    end else begin
      vsync_q      <= bus.vsync;
      frame_tick_q <= frame_start;
      btn_sync_q   <= {btn_sync_q[0], bus.next_btn};
      btn_prev_q   <= btn_sync_q[1];
    end
  end

  // -------------------------------------------------------------------------
  // Scheduler / pattern FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pattern_q   <= PAT_BARS;
      frame_cnt_q <= 8'd0;
      pending_q   <= 1'b0;
      solid_col_q <= 3'b111;
    end else begin
      pattern_q   <= pattern_d;
      frame_cnt_q <= frame_cnt_d;
      pending_q   <= pending_d;
      solid_col_q <= solid_col_d;
    end
  end

  // -------------------------------------------------------------------------
  // Scheduler / pattern FSM: next state
  // -------------------------------------------------------------------------
  always_comb begin
    pattern_d   = pattern_q;
    frame_cnt_d = frame_cnt_q;
    pending_d   = pending_q;
    solid_col_d = solid_col_q;
    advance     = 1'b0;

    if (frame_start) begin
      // A press that lands on the frame_start cycle itself is consumed here
      // rather than left pending for the following frame.
      if (pending_q || btn_edge) begin
        advance     = 1'b1;
        frame_cnt_d = 8'd0;
        pending_d   = 1'b0;
      end else if (!bus.hold) begin
        if (frame_cnt_q == FRAME_LAST) begin
          advance     = 1'b1;
          frame_cnt_d = 8'd0;
        end else begin
          frame_cnt_d = frame_cnt_q + 8'd1;
        end
      end
    end else if (btn_edge) begin
      // Repeated presses within a frame collapse into one pending advance.
      pending_d = 1'b1;
    end

    if (advance) begin
      case (pattern_q)
        PAT_BARS:    pattern_d = PAT_CHECKER;
        PAT_CHECKER: pattern_d = PAT_RAMP;
        PAT_RAMP:    pattern_d = PAT_SOLID;
        PAT_SOLID:   pattern_d = PAT_BARS;
        default:     pattern_d = PAT_BARS;
      endcase
    end

    // Solid colour restarts at white on entry and steps down once per frame
    // it stays in SOLID, skipping black.
    if (advance && (pattern_d == PAT_SOLID)) begin
      solid_col_d = 3'b111;
    end else if (frame_start && !advance && (pattern_q == PAT_SOLID)) begin
      solid_col_d = (solid_col_q == 3'b001) ? 3'b111 : solid_col_q - 3'd1;
    end
  end

  // -------------------------------------------------------------------------
  // Bar counters
  // -------------------------------------------------------------------------
  // The registered counters lag hpos by one pixel, so the pixel path uses
  // the next-state values to keep the bar boundaries at exact multiples of
  // BAR_WIDTH with a single cycle of output latency.
  always_comb begin
    bar_idx_d = bar_idx_q;
    bar_sub_d = bar_sub_q;
    if (bus.hpos == 9'd0) begin
      bar_idx_d = 3'd0;
      bar_sub_d = '0;
    end else if (bar_sub_q == BAR_LAST) begin
      bar_sub_d = '0;
      if (bar_idx_q != 3'd7) begin
        bar_idx_d = bar_idx_q + 3'd1;
      end
    end else begin
      bar_sub_d = bar_sub_q + SUB_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bar_idx_q <= 3'd0;
      bar_sub_q <= '0;
    end else begin
      bar_idx_q <= bar_idx_d;
      bar_sub_q <= bar_sub_d;
    end
  end

  function automatic logic [2:0] bar_colour(input logic [2:0] idx);
    logic [2:0] col;
    case (idx)
      3'd0:    col = 3'b111; // white
      3'd1:    col = 3'b110; // yellow
      3'd2:    col = 3'b011; // cyan
      3'd3:    col = 3'b010; // green
      3'd4:    col = 3'b101; // magenta
      3'd5:    col = 3'b100; // red
      3'd6:    col = 3'b001; // blue
      default: col = 3'b000; // black
    endcase
    return col;
  endfunction

  // -------------------------------------------------------------------------
  // Pixel path
  // -------------------------------------------------------------------------
`ifdef PATTERN_OSD_EN
  logic [2:0] osd_blocks;
  logic       osd_hit;
  // Marker spans 8*(pattern_id+1) columns; column 7 of each block is a gap.
  assign osd_blocks = {1'b0, pattern_q} + 3'd1;
  assign osd_hit    = (bus.vpos < 9'd8) &&
                      (bus.hpos < {3'b000, osd_blocks, 3'b000}) &&
                      (bus.hpos[2:0] != 3'b111);
`else
  // Only vpos[4] feeds the pixel path when the marker is not built.
  logic unused_vpos;
  assign unused_vpos = &{1'b0, bus.vpos[8:5], bus.vpos[3:0]};
`endif

  always_comb begin
    rgb_d = 3'b000;
    if (bus.display_on) begin
      case (pattern_q)
        PAT_BARS:    rgb_d = bar_colour(bar_idx_d);
        PAT_CHECKER: rgb_d = {3{bus.hpos[4] ^ bus.vpos[4]}};
        PAT_RAMP:    rgb_d = bus.hpos[7:5];
        PAT_SOLID:   rgb_d = solid_col_q;
        default:     rgb_d = 3'b000;
      endcase
`ifdef PATTERN_OSD_EN
      if (osd_hit) begin
        rgb_d = 3'b111;
      end
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rgb_q <= 3'b000;
    end else begin
      rgb_q <= rgb_d;
    end
  end

  assign bus.pattern_id = pattern_q;
  assign bus.frame_tick = frame_tick_q;
  assign bus.rgb        = rgb_q;

endmodule

// File: tb/tb_test_pattern_sequencer.sv
module tb_test_pattern_sequencer;

  logic clk;
  logic reset;
  int   n_assert;
  int   n_fail;

  test_pattern_sequencer_if vif();

  test_pattern_sequencer #(
    .H_DISPLAY          (256),
    .BAR_WIDTH          (36),
    .FRAMES_PER_PATTERN (2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (vif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached, observed=running required=finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One vsync pulse in blanking; frame_tick must pulse exactly one cycle.
  task automatic do_frame();
    vif.display_on = 1'b0;
    vif.hpos       = 9'd0;
    vif.vsync      = 1'b1;
    tick();
    chk("frame_tick_hi", {8'd0, vif.frame_tick}, 9'd1);
    tick();
    chk("frame_tick_lo", {8'd0, vif.frame_tick}, 9'd0);
    vif.vsync = 1'b0;
    repeat (3) tick();
  endtask

  task automatic btn_pulse();
    vif.next_btn = 1'b1;
    repeat (2) tick();
    vif.next_btn = 1'b0;
    repeat (3) tick();
  endtask

  // Single visible pixel at hpos=10, vpos=100.
  task automatic pixel_chk(input string tag, input logic [2:0] exp);
    vif.vpos       = 9'd100;
    vif.hpos       = 9'd10;
    vif.display_on = 1'b1;
    tick();
    chk(tag, {6'd0, vif.rgb}, {6'd0, exp});
    vif.display_on = 1'b0;
    vif.hpos       = 9'd0;
    tick();
  endtask

  function automatic logic [2:0] bars_exp(input int h);
    logic [2:0] tab [8];
    int idx;
    tab = '{3'b111, 3'b110, 3'b011, 3'b010, 3'b101, 3'b100, 3'b001, 3'b000};
    idx = h / 36;
    if (idx > 7) idx = 7;
    return tab[idx];
  endfunction

  initial begin
    logic [8:0] hv;
    logic [2:0] solid_seq [7];
    logic [2:0] exp_px;
    n_assert = 0;
    n_fail   = 0;
    solid_seq = '{3'b110, 3'b101, 3'b100, 3'b011, 3'b010, 3'b001, 3'b111};

    reset          = 1'b1;
    vif.hpos       = 9'd0;
    vif.vpos       = 9'd0;
    vif.display_on = 1'b0;
    vif.vsync      = 1'b0;
    vif.next_btn   = 1'b0;
    vif.hold       = 1'b0;
    repeat (3) tick();
    chk("reset_pattern", {7'd0, vif.pattern_id}, 9'd0);
    chk("reset_rgb", {6'd0, vif.rgb}, 9'd0);
    chk("reset_tick", {8'd0, vif.frame_tick}, 9'd0);
    reset = 1'b0;
    tick();

    // SMPTE bars across one full line, then blanking.
    vif.vpos = 9'd10;
    for (int h = 0; h < 256; h++) begin
      vif.hpos       = 9'(h);
      vif.display_on = 1'b1;
      tick();
      chk($sformatf("bars_h%0d", h), {6'd0, vif.rgb}, {6'd0, bars_exp(h)});
    end
    vif.display_on = 1'b0;
    vif.hpos       = 9'd0;
    tick();
    chk("bars_blank", {6'd0, vif.rgb}, 9'd0);

    // Auto-advance every 2 frames through all patterns.
    for (int f = 1; f <= 8; f++) begin
      do_frame();
      chk($sformatf("auto_f%0d", f), {7'd0, vif.pattern_id}, 9'((f / 2) % 4));
      if (f == 2) begin
        vif.vpos = 9'd16;
        for (int h = 0; h < 64; h++) begin
          hv             = 9'(h);
          vif.hpos       = hv;
          vif.display_on = 1'b1;
          tick();
          chk($sformatf("checker_h%0d", h), {6'd0, vif.rgb}, {6'd0, {3{hv[4] ^ 1'b1}}});
        end
        vif.display_on = 1'b0;
        vif.hpos       = 9'd0;
        tick();
      end
      if (f == 4) begin
        vif.vpos = 9'd40;
        for (int h = 0; h < 256; h += 13) begin
          hv             = 9'(h);
          vif.hpos       = hv;
          vif.display_on = 1'b1;
          tick();
          chk($sformatf("ramp_h%0d", h), {6'd0, vif.rgb}, {6'd0, hv[7:5]});
        end
        vif.display_on = 1'b0;
        vif.hpos       = 9'd0;
        tick();
      end
      if (f == 6) pixel_chk("solid_entry", 3'b111);
    end

    // Hold freezes both pattern and frame count.
    do_frame();
    chk("pre_hold", {7'd0, vif.pattern_id}, 9'd0);
    vif.hold = 1'b1;
    for (int f = 0; f < 10; f++) begin
      do_frame();
      chk($sformatf("hold_f%0d", f), {7'd0, vif.pattern_id}, 9'd0);
    end
    vif.hold = 1'b0;
    do_frame();
    chk("hold_release_cnt_kept", {7'd0, vif.pattern_id}, 9'd1);

    // Three presses within one frame give a single advance.
    vif.hold = 1'b1;
    btn_pulse();
    btn_pulse();
    btn_pulse();
    chk("btn_no_midframe_adv", {7'd0, vif.pattern_id}, 9'd1);
    do_frame();
    chk("btn_adv_once", {7'd0, vif.pattern_id}, 9'd2);
    do_frame();
    chk("btn_no_second_adv", {7'd0, vif.pattern_id}, 9'd2);
    vif.hold = 1'b0;
    do_frame();
    chk("btn_cnt_zero_a", {7'd0, vif.pattern_id}, 9'd2);
    do_frame();
    chk("btn_cnt_zero_b", {7'd0, vif.pattern_id}, 9'd3);

    // SOLID colour cycling under hold.
    vif.hold = 1'b1;
    pixel_chk("solid_0", 3'b111);
    for (int f = 0; f < 7; f++) begin
      do_frame();
      pixel_chk($sformatf("solid_%0d", f + 1), solid_seq[f]);
    end
    chk("solid_pattern", {7'd0, vif.pattern_id}, 9'd3);

    // Button edge coincident with frame_start: synchroniser takes 2 cycles.
    vif.next_btn = 1'b1;
    tick();
    tick();
    vif.vsync = 1'b1;
    tick();
    chk("coinc_adv", {7'd0, vif.pattern_id}, 9'd0);
    chk("coinc_tick", {8'd0, vif.frame_tick}, 9'd1);
    vif.vsync    = 1'b0;
    vif.next_btn = 1'b0;
    repeat (3) tick();
    do_frame();
    chk("coinc_no_second", {7'd0, vif.pattern_id}, 9'd0);

    // Reach RAMP by buttons, then reset mid-line.
    btn_pulse();
    do_frame();
    btn_pulse();
    do_frame();
    chk("ramp_reached", {7'd0, vif.pattern_id}, 9'd2);
    vif.vpos = 9'd50;
    for (int h = 0; h <= 100; h++) begin
      vif.hpos       = 9'(h);
      vif.display_on = 1'b1;
      tick();
    end
    chk("ramp_h100", {6'd0, vif.rgb}, 9'd3);
    reset = 1'b1;
    #1;
    chk("async_rst_rgb", {6'd0, vif.rgb}, 9'd0);
    chk("async_rst_pattern", {7'd0, vif.pattern_id}, 9'd0);
    vif.display_on = 1'b0;
    vif.hpos       = 9'd0;
    vif.hold       = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    chk("post_rst_tick", {8'd0, vif.frame_tick}, 9'd0);
    do_frame();
    chk("post_rst_f1", {7'd0, vif.pattern_id}, 9'd0);
    do_frame();
    chk("post_rst_f2", {7'd0, vif.pattern_id}, 9'd1);

    // Top-left marker region in RAMP (pattern_id=2).
    vif.hold = 1'b1;
    btn_pulse();
    do_frame();
    chk("osd_pattern", {7'd0, vif.pattern_id}, 9'd2);
    vif.vpos = 9'd3;
    for (int h = 0; h < 32; h++) begin
      hv             = 9'(h);
      vif.hpos       = hv;
      vif.display_on = 1'b1;
      tick();
      exp_px = hv[7:5];
`ifdef PATTERN_OSD_EN
      if (h < 24 && hv[2:0] != 3'b111) exp_px = 3'b111;
`endif
      chk($sformatf("osd_h%0d", h), {6'd0, vif.rgb}, {6'd0, exp_px});
    end
    vif.display_on = 1'b0;
    tick();
    chk("osd_blank", {6'd0, vif.rgb}, 9'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
